// File: rtl/audio_out_mc.sv
// ---------------------------------------------------------------------------
// audio_out_mc
//
// Multichannel audio output stage. Packed PCM frames arrive over a
// valid/ready handshake and are queued in a small frame FIFO. Each external
// sample tick releases one frame to the held output samples, with a global
// arithmetic-shift attenuation and a mute applied on the way out. Every
// channel also drives a first-order sigma-delta bitstream for analog or PWM
// pins.
//
// Parameters
//   CHANNELS  channel count (>= 1)
//   WIDTH     signed two's complement sample width (>= 4)
//   DEPTH     FIFO depth in frames, power of two (>= 2)
//
// Ports
//   clk           single clock for all logic
//   reset_n       asynchronous active-low reset
//   in_data       input frame, channel c at [c*WIDTH +: WIDTH]
//   in_valid      input frame offered
//   in_ready      FIFO can accept (enable && not full)
//   enable        block enable; low flushes the FIFO and silences the output
//   sample_tick   one-cycle sample-rate strobe
//   atten         arithmetic right-shift applied to every channel at pop
//   mute          force output samples to zero
//   level         held output samples, same packing as in_data
//   sample_stb    one-cycle pulse when level takes a newly popped frame
//   fill          frames currently in the FIFO
//   underrun_cnt  saturating count of ticks that found the FIFO empty
//   dac_out       sigma-delta bit per channel
// ---------------------------------------------------------------------------
module audio_out_mc #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [CHANNELS*WIDTH-1:0]     in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          enable,
    input  logic                          sample_tick,
    input  logic [3:0]                    atten,
    input  logic                          mute,
    output logic [CHANNELS*WIDTH-1:0]     level,
    output logic                          sample_stb,
    output logic [$clog2(DEPTH+1)-1:0]    fill,
    output logic [7:0]                    underrun_cnt,
    output logic [CHANNELS-1:0]           dac_out
);

    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(DEPTH);

    typedef logic [CHANNELS*WIDTH-1:0] frame_t;

    // Arithmetic right shift; shifts of WIDTH or more leave only sign bits.
    function automatic logic signed [WIDTH-1:0] atten_shift(
        input logic signed [WIDTH-1:0] x,
        input logic [3:0]              sh
    );
        if (int'(sh) >= WIDTH) begin
            return {WIDTH{x[WIDTH-1]}};
        end
        return x >>> sh;
    endfunction

    // Saturating event counter step.
    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    // Two's complement to offset binary: flipping the sign bit maps
    // -2^(W-1)..2^(W-1)-1 onto 0..2^W-1, the pulse density numerator.
    function automatic logic [WIDTH-1:0] offset_bin(input logic signed [WIDTH-1:0] x);
        return {~x[WIDTH-1], x[WIDTH-2:0]};
    endfunction

    frame_t              mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic                push;
    logic                pop;
    logic                underrun;
    frame_t              head_p0;
    frame_t              scaled_p0;
    logic [WIDTH-1:0]    dac_acc_p1 [CHANNELS];
    logic [WIDTH:0]      dac_sum_p1 [CHANNELS];

    assign in_ready = enable && (fill != FULL);
    assign push     = in_valid && in_ready;
    assign pop      = sample_tick && enable && (fill != '0);
    assign underrun = sample_tick && enable && (fill == '0);

    // ---- stage 0: FIFO head read and attenuation ----
    assign head_p0 = mem[rd_ptr];

    always_comb begin
        scaled_p0 = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            scaled_p0[c*WIDTH +: WIDTH] = atten_shift(head_p0[c*WIDTH +: WIDTH], atten);
        end
    end

    // Frame storage carries data only, so it has no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // ---- stage 1: FIFO control and held output samples ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill         <= '0;
            underrun_cnt <= '0;
            sample_stb   <= 1'b0;
            level        <= '0;
        end else if (!enable) begin
            // Flush and silence; the underrun history is kept on purpose.
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
            sample_stb <= 1'b0;
            level      <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fill <= fill + FILL_W'(1);
            end else if (pop && !push) begin
                fill <= fill - FILL_W'(1);
            end
            if (underrun) begin
                underrun_cnt <= sat_inc(underrun_cnt);
            end
            sample_stb <= pop;
            // Mute zeroes the output every cycle; popped frames are discarded
            // so the FIFO keeps draining at the sample rate.
            if (mute) begin
                level <= '0;
            end else if (pop) begin
                level <= scaled_p0;
            end
        end
    end

    // ---- stage 2: sigma-delta modulators ----
    // The accumulator keeps only its low WIDTH bits; the carry out of each
    // addition is the output bit, so acc[WIDTH] lives in dac_out.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            dac_sum_p1[c] = {1'b0, dac_acc_p1[c]} + {1'b0, offset_bin(level[c*WIDTH +: WIDTH])};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                dac_acc_p1[c] <= '0;
            end
            dac_out <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                dac_acc_p1[c] <= dac_sum_p1[c][WIDTH-1:0];
                dac_out[c]    <= dac_sum_p1[c][WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_audio_out_mc.sv
module tb_audio_out_mc;

    localparam int CH = 2;
    localparam int W  = 16;
    localparam int D  = 4;

    typedef logic [CH*W-1:0] frame_t;

    logic            clk = 1'b0;
    logic            reset_n;
    frame_t          in_data;
    logic            in_valid;
    logic            in_ready;
    logic            enable;
    logic            sample_tick;
    logic [3:0]      atten;
    logic            mute;
    frame_t          level;
    logic            sample_stb;
    logic [2:0]      fill;
    logic [7:0]      underrun_cnt;
    logic [CH-1:0]   dac_out;

    always #5 clk = ~clk;

    audio_out_mc #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .enable       (enable),
        .sample_tick  (sample_tick),
        .atten        (atten),
        .mute         (mute),
        .level        (level),
        .sample_stb   (sample_stb),
        .fill         (fill),
        .underrun_cnt (underrun_cnt),
        .dac_out      (dac_out)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_total++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    endtask

    // Reference: value as a signed integer, divided by 2^sh rounding toward
    // minus infinity (what an arithmetic shift means numerically).
    function automatic logic [W-1:0] ref_chan(input logic [W-1:0] raw, input int sh, input bit m);
        int v, d, q;
        if (m) return '0;
        v = int'(raw);
        if (raw[W-1]) v = v - (1 << W);
        if (sh >= W) begin
            q = (v < 0) ? -1 : 0;
        end else begin
            d = 1 << sh;
            q = v / d;
            if (v < 0 && (v % d) != 0) q = q - 1;
        end
        return W'(q);
    endfunction

    function automatic frame_t ref_frame(input frame_t f, input int sh, input bit m);
        frame_t r;
        for (int c = 0; c < CH; c++) r[c*W +: W] = ref_chan(f[c*W +: W], sh, m);
        return r;
    endfunction

    // Behavioural model: a queue of frames plus the expected held output.
    frame_t model_q[$];
    frame_t exp_q[$];
    frame_t exp_level;
    int     exp_under;
    int     mdl_n;
    frame_t mdl_f;

    always @(posedge clk) begin
        if (!reset_n) begin
            model_q.delete();
            exp_q.delete();
            exp_level = '0;
            exp_under = 0;
        end else if (!enable) begin
            model_q.delete();
            exp_level = '0;
        end else begin
            mdl_n = model_q.size();
            if (sample_tick) begin
                if (mdl_n != 0) begin
                    mdl_f     = model_q.pop_front();
                    exp_level = ref_frame(mdl_f, int'(atten), mute);
                    exp_q.push_back(exp_level);
                end else if (exp_under < 255) begin
                    exp_under++;
                end
            end
            if (mute) exp_level = '0;
            if (in_valid && mdl_n != D) model_q.push_back(in_data);
        end
    end

    // Monitor: compares every presented sample against the scoreboard and
    // tracks the visible state against the model each cycle.
    int stb_seen = 0;
    bit track    = 1'b0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (sample_stb) begin
                stb_seen++;
                if (exp_q.size() == 0) check("unexpected_stb", 64'(sample_stb), 64'd0);
                else check("popped_level", 64'(level), 64'(exp_q.pop_front()));
            end
            if (track) begin
                check("fill_track", 64'(fill), 64'(model_q.size()));
                check("level_track", 64'(level), 64'(exp_level));
                check("ready_track", 64'(in_ready), 64'(enable && model_q.size() != D));
                check("underrun_track", 64'(underrun_cnt), 64'(exp_under));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    frame_t fr [5];
    int     ones0, ones1, s0;

    initial begin
        reset_n = 1'b0; enable = 1'b1; in_valid = 1'b0; in_data = '0;
        sample_tick = 1'b0; atten = 4'd0; mute = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_fill", 64'(fill), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_underrun", 64'(underrun_cnt), 64'd0);
        check("rst_dac", 64'(dac_out), 64'd0);
        check("rst_stb", 64'(sample_stb), 64'd0);
        cyc();
        reset_n = 1'b1;
        track   = 1'b1;

        // Idle level 0 is mid-scale: half density on every channel.
        ones0 = 0; ones1 = 0;
        repeat (2048) begin
            @(negedge clk);
            ones0 += int'(dac_out[0]);
            ones1 += int'(dac_out[1]);
        end
        check_range("idle_density_ch0", ones0, 1023, 1025);
        check_range("idle_density_ch1", ones1, 1023, 1025);

        // Fill to full, then a tick frees room for the held fifth frame.
        fr[0] = {16'h8000, 16'h1234};
        fr[1] = fr[0];
        fr[2] = fr[0];
        fr[3] = {16'($urandom), 16'($urandom)};
        fr[4] = {16'($urandom), 16'($urandom)};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = fr[i];
            cyc();
        end
        in_data = fr[4];
        @(negedge clk);
        check("full_fill", 64'(fill), 64'd4);
        check("full_ready", 64'(in_ready), 64'd0);
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        @(negedge clk);
        check("pop0_level", 64'(level), 64'h8000_1234);
        check("pop0_stb", 64'(sample_stb), 64'd1);
        check("pop0_fill", 64'(fill), 64'd3);
        check("pop0_ready", 64'(in_ready), 64'd1);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        check("held_accept_fill", 64'(fill), 64'd4);
        check("stb_one_cycle", 64'(sample_stb), 64'd0);

        // Attenuation, including the shift that leaves only sign bits.
        atten = 4'd2; sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        @(negedge clk);
        check("atten2_level", 64'(level), 64'hE000_048D);
        atten = 4'd15; sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        @(negedge clk);
        check("atten15_level", 64'(level), 64'hFFFF_0000);
        for (int i = 0; i < 2; i++) begin
            atten = 4'($urandom_range(0, 15)); sample_tick = 1'b1;
            cyc();
        end
        sample_tick = 1'b0; atten = 4'd0;
        @(negedge clk);
        check("drained_fill", 64'(fill), 64'd0);

        // Underruns: count, hold level, then saturate.
        sample_tick = 1'b1;
        repeat (3) cyc();
        sample_tick = 1'b0;
        @(negedge clk);
        check("underrun3", 64'(underrun_cnt), 64'd3);
        check("underrun_level_held", 64'(level), 64'(exp_level));
        sample_tick = 1'b1;
        repeat (300) cyc();
        sample_tick = 1'b0;
        @(negedge clk);
        check("underrun_sat", 64'(underrun_cnt), 64'd255);

        // Randomised traffic against the model.
        repeat (3000) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_data     = {16'($urandom), 16'($urandom)};
            sample_tick = ($urandom_range(0, 2) == 0);
            atten       = 4'($urandom_range(0, 15));
            mute        = ($urandom_range(0, 7) == 0);
            enable      = ($urandom_range(0, 199) != 0);
            cyc();
        end
        in_valid = 1'b0; sample_tick = 1'b0; mute = 1'b0; atten = 4'd0;
        enable = 1'b0;
        cyc();
        enable = 1'b1;
        cyc();

        // Held DC levels: 0x4000 gives 3/4 density, 0x8000 gives none.
        in_valid = 1'b1; in_data = {16'h8000, 16'h4000};
        cyc();
        in_valid = 1'b0; sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        repeat (3) cyc();
        ones0 = 0; ones1 = 0;
        repeat (1024) begin
            @(negedge clk);
            ones0 += int'(dac_out[0]);
            ones1 += int'(dac_out[1]);
        end
        check_range("dc_density_ch0", ones0, 767, 769);
        check_range("dc_density_ch1", ones1, 0, 0);

        // Flush with enable low, then muted draining.
        cyc();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = {16'($urandom), 16'($urandom)};
            cyc();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("preflush_fill", 64'(fill), 64'd3);
        enable = 1'b0;
        cyc();
        enable = 1'b1;
        @(negedge clk);
        check("flush_fill", 64'(fill), 64'd0);
        check("flush_level", 64'(level), 64'd0);
        check("flush_underrun_kept", 64'(underrun_cnt), 64'd255);
        cyc();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = {16'($urandom_range(1, 16'h7FFF)), 16'($urandom_range(1, 16'h7FFF))};
            cyc();
        end
        in_valid = 1'b0;
        mute = 1'b1;
        s0 = stb_seen;
        sample_tick = 1'b1;
        repeat (2) cyc();
        sample_tick = 1'b0;
        cyc();
        @(negedge clk);
        check("mute_stb_count", 64'(stb_seen - s0), 64'd2);
        check("mute_level", 64'(level), 64'd0);
        check("mute_fill", 64'(fill), 64'd0);
        mute = 1'b0;

        repeat (3) cyc();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
